// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states,
// opcode/funct constants and ALU / mux select codes.
package multi_cycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPEEX  = 4'd6,
        S_RTYPEWB  = 4'd7,
        S_BRANCHEX = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JEX      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUB_REG   = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// R-type funct decode: ALU operation plus a flag marking the funct as legal,
// so the writeback state can suppress register writes for unknown functs.
module alu_decoder
    import multi_cycle_controller_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       funct_ok_o
);

    // Map funct to ALU op; unknown functs fall back to add and are flagged.
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        funct_ok_o = 1'b1;
        case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: begin
                alu_ctrl_o = ALU_ADD;
                funct_ok_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore FSM controller for a multi-cycle MIPS datapath. Outputs are a pure
// function of state except pc_en in BRANCHEX, which follows the ALU zero flag.
// All outputs are forced low while reset is held.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic [2:0] rtype_ctrl;
    logic       funct_ok;

    logic       pc_en_c, i_or_d_c, mem_write_c, ir_write_c;
    logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, pc_src_c;
    logic [2:0] alu_ctrl_c;

    alu_decoder u_alu_decoder (
        .funct_i    (funct),
        .alu_ctrl_o (rtype_ctrl),
        .funct_ok_o (funct_ok)
    );

    // State register; reset snaps straight back to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d      = S_FETCH;
        pc_en_c      = 1'b0;
        i_or_d_c     = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = ALUB_REG;
        alu_ctrl_c   = ALU_AND;
        pc_src_c     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                ir_write_c  = 1'b1;
                pc_en_c     = 1'b1;
                alu_src_b_c = ALUB_FOUR;
                alu_ctrl_c  = ALU_ADD;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // Precompute branch target into ALUOut while decoding.
                alu_src_b_c = ALUB_IMMSH;
                alu_ctrl_c  = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = S_RTYPEEX;
                    OP_BEQ, OP_BNE: state_d = S_BRANCHEX;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JEX;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = ALUB_IMM;
                alu_ctrl_c  = ALU_ADD;
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                i_or_d_c = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            S_MEMWR: begin
                i_or_d_c    = 1'b1;
                mem_write_c = 1'b1;
            end
            S_RTYPEEX: begin
                alu_src_a_c = 1'b1;
                alu_ctrl_c  = rtype_ctrl;
                state_d     = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                reg_dst_c   = 1'b1;
                reg_write_c = funct_ok;
            end
            S_BRANCHEX: begin
                alu_src_a_c = 1'b1;
                alu_ctrl_c  = ALU_SUB;
                pc_src_c    = PCSRC_ALUOUT;
                if (opcode == OP_BEQ)      pc_en_c = zero;
                else if (opcode == OP_BNE) pc_en_c = ~zero;
            end
            S_ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = ALUB_IMM;
                alu_ctrl_c  = ALU_ADD;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c = 1'b1;
            end
            S_JEX: begin
                pc_src_c = PCSRC_JUMP;
                pc_en_c  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every output, including the FETCH strobes.
    assign pc_en      = reset & pc_en_c;
    assign i_or_d     = reset & i_or_d_c;
    assign mem_write  = reset & mem_write_c;
    assign ir_write   = reset & ir_write_c;
    assign reg_dst    = reset & reg_dst_c;
    assign mem_to_reg = reset & mem_to_reg_c;
    assign reg_write  = reset & reg_write_c;
    assign alu_src_a  = reset & alu_src_a_c;
    assign alu_src_b  = {2{reset}} & alu_src_b_c;
    assign alu_ctrl   = {3{reset}} & alu_ctrl_c;
    assign pc_src     = {2{reset}} & pc_src_c;
    assign state      = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench: each stimulus cycle pushes the expected output vector
// {state, 8 strobes, alu_src_b, alu_ctrl, pc_src}; a monitor pops and
// compares on every falling edge.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state;

    multi_cycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .pc_src(pc_src), .state(state)
    );

    always #5 clk = ~clk;

    // state | pc_en i_or_d mem_wr ir_wr reg_dst m2r reg_wr srcA | srcB | alu | pcsrc
    localparam logic [18:0] V_ZERO    = 19'b0000_00000000_00_000_00;
    localparam logic [18:0] V_FETCH   = 19'b0000_10010000_01_010_00;
    localparam logic [18:0] V_DECODE  = 19'b0001_00000000_11_010_00;
    localparam logic [18:0] V_MEMADR  = 19'b0010_00000001_10_010_00;
    localparam logic [18:0] V_MEMRD   = 19'b0011_01000000_00_000_00;
    localparam logic [18:0] V_MEMWB   = 19'b0100_00000110_00_000_00;
    localparam logic [18:0] V_MEMWR   = 19'b0101_01100000_00_000_00;
    localparam logic [18:0] V_RTEX_SL = 19'b0110_00000001_00_111_00;
    localparam logic [18:0] V_RTEX_DF = 19'b0110_00000001_00_010_00;
    localparam logic [18:0] V_RTWB_OK = 19'b0111_00001010_00_000_00;
    localparam logic [18:0] V_RTWB_NO = 19'b0111_00001000_00_000_00;
    localparam logic [18:0] V_BR_T    = 19'b1000_10000001_00_110_01;
    localparam logic [18:0] V_BR_N    = 19'b1000_00000001_00_110_01;
    localparam logic [18:0] V_ADDIEX  = 19'b1001_00000001_10_010_00;
    localparam logic [18:0] V_ADDIWB  = 19'b1010_00000010_00_000_00;
    localparam logic [18:0] V_JEX     = 19'b1011_10000000_00_000_10;

    logic [18:0] sb[$];
    int n_vec = 0;
    int n_err = 0;

    wire [18:0] act = {state, pc_en, i_or_d, mem_write, ir_write, reg_dst,
                       mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src};

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            logic [18:0] e;
            e = sb.pop_front();
            n_vec++;
            if (act !== e) begin
                n_err++;
                $display("FAIL vec%0d t=%0t got=%b exp=%b", n_vec, $time, act, e);
            end
        end
    end

    // One cycle: drive inputs just after the edge, queue that cycle's expectation.
    task automatic step(input logic [18:0] e, input logic [5:0] op,
                        input logic [5:0] fn, input logic z);
        @(posedge clk);
        #1;
        opcode = op;
        funct  = fn;
        zero   = z;
        sb.push_back(e);
    endtask

    initial begin
        // Held in reset: everything low.
        step(V_ZERO, 6'h23, 6'h00, 1'b0);
        step(V_ZERO, 6'h23, 6'h00, 1'b0);
        // Release between edges: FETCH strobes appear before the first edge.
        @(posedge clk);
        #2 reset = 1'b1;
        sb.push_back(V_FETCH);

        // lw: 0,1,2,3,4,0
        step(V_DECODE,  6'h23, 6'h00, 1'b0);
        step(V_MEMADR,  6'h23, 6'h00, 1'b0);
        step(V_MEMRD,   6'h23, 6'h00, 1'b0);
        step(V_MEMWB,   6'h23, 6'h00, 1'b0);
        // R-type slt, then illegal funct
        step(V_FETCH,   6'h00, 6'h2A, 1'b0);
        step(V_DECODE,  6'h00, 6'h2A, 1'b0);
        step(V_RTEX_SL, 6'h00, 6'h2A, 1'b0);
        step(V_RTWB_OK, 6'h00, 6'h2A, 1'b0);
        step(V_FETCH,   6'h00, 6'h3F, 1'b0);
        step(V_DECODE,  6'h00, 6'h3F, 1'b0);
        step(V_RTEX_DF, 6'h00, 6'h3F, 1'b0);
        step(V_RTWB_NO, 6'h00, 6'h3F, 1'b0);
        // beq taken / not taken, bne taken / not taken
        step(V_FETCH,   6'h04, 6'h00, 1'b0);
        step(V_DECODE,  6'h04, 6'h00, 1'b0);
        step(V_BR_T,    6'h04, 6'h00, 1'b1);
        step(V_FETCH,   6'h04, 6'h00, 1'b0);
        step(V_DECODE,  6'h04, 6'h00, 1'b0);
        step(V_BR_N,    6'h04, 6'h00, 1'b0);
        step(V_FETCH,   6'h05, 6'h00, 1'b0);
        step(V_DECODE,  6'h05, 6'h00, 1'b0);
        step(V_BR_N,    6'h05, 6'h00, 1'b1);
        step(V_FETCH,   6'h05, 6'h00, 1'b0);
        step(V_DECODE,  6'h05, 6'h00, 1'b0);
        step(V_BR_T,    6'h05, 6'h00, 1'b0);
        // addi
        step(V_FETCH,   6'h08, 6'h00, 1'b0);
        step(V_DECODE,  6'h08, 6'h00, 1'b0);
        step(V_ADDIEX,  6'h08, 6'h00, 1'b0);
        step(V_ADDIWB,  6'h08, 6'h00, 1'b0);
        // illegal opcode: 0,1,0
        step(V_FETCH,   6'h3F, 6'h00, 1'b0);
        step(V_DECODE,  6'h3F, 6'h00, 1'b0);
        // sw then j back to back
        step(V_FETCH,   6'h2B, 6'h00, 1'b0);
        step(V_DECODE,  6'h2B, 6'h00, 1'b0);
        step(V_MEMADR,  6'h2B, 6'h00, 1'b0);
        step(V_MEMWR,   6'h2B, 6'h00, 1'b0);
        step(V_FETCH,   6'h02, 6'h00, 1'b0);
        step(V_DECODE,  6'h02, 6'h00, 1'b0);
        step(V_JEX,     6'h02, 6'h00, 1'b0);
        // sw aborted by reset 3 ns into MEMWR
        step(V_FETCH,   6'h2B, 6'h00, 1'b0);
        step(V_DECODE,  6'h2B, 6'h00, 1'b0);
        step(V_MEMADR,  6'h2B, 6'h00, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        sb.push_back(V_ZERO);
        step(V_ZERO,    6'h2B, 6'h00, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        sb.push_back(V_FETCH);
        step(V_DECODE,  6'h2B, 6'h00, 1'b0);
        step(V_MEMADR,  6'h2B, 6'h00, 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameters: none; opcode and state encodings are fixed constants from the shared package.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instr[31:26], taken from the datapath instruction register.
REQ-005 funct  input  6  instr[5:0].
REQ-006 zero  input  1  ALU zero flag, combinational from the datapath.
REQ-007 pc_en  output  1  PC register load enable.
REQ-008 i_or_d  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-009 mem_write  output  1  unified memory write strobe.
REQ-010 ir_write  output  1  instruction register load.
REQ-011 reg_dst  output  1  write register select: 0=rt, 1=rd.
REQ-012 mem_to_reg  output  1  writeback source: 0=ALUOut, 1=MDR.
REQ-013 reg_write  output  1  register file write enable.
REQ-014 alu_src_a  output  1  ALU A select: 0=PC, 1=A reg.
REQ-015 alu_src_b  output  2  ALU B select: 00=B reg, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-016 alu_ctrl  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-017 pc_src  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-018 state  output  4  current state, for debug and the bench only.

Function
REQ-019 The block SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BRANCHEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-020 In FETCH: ir_write=1, pc_en=1, alu_src_a=0, alu_src_b=01, alu_ctrl=010, pc_src=00; next state is DECODE.
REQ-021 In DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=010 (branch target into ALUOut).
REQ-022 DECODE next state by opcode:
  - 0x23 or 0x2B -> MEMADR
  - 0x00 -> RTYPEEX
  - 0x04 or 0x05 -> BRANCHEX
  - 0x08 -> ADDIEX
  - 0x02 -> JEX
  - any other opcode -> FETCH, with no write strobe asserted.
REQ-023 MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=010. MEMADR goes to MEMRD for 0x23 and to MEMWR for 0x2B; ADDIEX goes to ADDIWB.
REQ-024 MEMRD: i_or_d=1; next state MEMWB. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-025 MEMWR: i_or_d=1, mem_write=1; next state FETCH.
REQ-026 RTYPEEX: alu_src_a=1, alu_src_b=00, alu_ctrl decoded from funct:
  - 0x20 -> 010
  - 0x22 -> 110
  - 0x24 -> 000
  - 0x25 -> 001
  - 0x2A -> 111
  - any other funct -> 010.
  Next state is RTYPEWB.
REQ-027 RTYPEWB: reg_dst=1, mem_to_reg=0; reg_write=1 only for the five legal funct codes, otherwise 0; next state FETCH.
REQ-028 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-029 BRANCHEX: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01; pc_en=zero for 0x04 and pc_en=~zero for 0x05; this is the only combinational output path. Next state is FETCH.
REQ-030 JEX: pc_src=10, pc_en=1; next state FETCH.
REQ-031 Any output not listed for a state SHALL be 0.
REQ-032 Instruction latency in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal opcode 2.
REQ-033 Any unused state encoding (12-15) SHALL return to FETCH on the next clock with all outputs 0.

Reset
REQ-034 reset=0 SHALL force state to FETCH immediately, regardless of clk.
REQ-035 While reset is held low, all outputs SHALL be 0, including the FETCH strobes ir_write and pc_en.
REQ-036 After reset deasserts, the first rising edge SHALL be a FETCH cycle with strobes active.
REQ-037 Reset asserted mid-instruction SHALL abort the instruction with no further write strobe.

Structure
REQ-038 A shared package SHALL hold the state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J), funct constants and alu_ctrl codes.
REQ-039 The funct-to-alu_ctrl decode SHALL be a separate combinational sub-module named alu_decoder; the FSM stays in multi_cycle_controller.

Verification
REQ-040 Release reset, then opcode=0x23 -> state sequence 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4.
REQ-041 opcode=0x00, funct=0x2A -> alu_ctrl=111 in RTYPEEX; reg_write=1 and reg_dst=1 in RTYPEWB; then funct=0x3F -> reg_write=0 in RTYPEWB.
REQ-042 opcode=0x04: zero=1 -> pc_en=1 in BRANCHEX; zero=0 -> pc_en=0. opcode=0x05: responses inverted.
REQ-043 opcode=0x3F -> sequence 0,1,0, with mem_write=0 and reg_write=0 throughout.
REQ-044 Assert reset 3 ns after the MEMWR clock edge (not aligned to clk) -> state=0 and mem_write=0 within the same cycle; after release, the first edge shows ir_write=1.
REQ-045 opcode=0x2B then 0x02 back to back -> sequences 0,1,2,5 then 0,1,11; pc_src=10 and pc_en=1 in JEX.
